// File: rtl/scan_test_ctrl.sv
// Tester-side scan controller: loads a pattern serially, runs functional capture, unloads and compares.
// Latency 2*CHAIN_LEN+CAPTURE_CYCLES from accept to done; start is ignored while busy.
module scan_test_ctrl #(
  parameter int CHAIN_LEN      = 8,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expected_in,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 cap_en,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response,
  output logic [CHAIN_LEN-1:0] fail_bits
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int CW = $clog2(CAPTURE_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(CAPTURE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [CW-1:0] CAP_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_IN, S_CAPTURE, S_SHIFT_OUT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]        cap_cnt_q, cap_cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] unload_q, unload_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 cap_en_q, cap_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [CHAIN_LEN-1:0] response_q, response_d;
  logic [CHAIN_LEN-1:0] fail_bits_q, fail_bits_d;
  logic                 start_ok;

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      cap_cnt_q   <= '0;
      pat_q       <= '0;
      exp_q       <= '0;
      unload_q    <= '0;
      scan_en_q   <= 1'b0;
      scan_in_q   <= 1'b0;
      cap_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      response_q  <= '0;
      fail_bits_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      pat_q       <= pat_d;
      exp_q       <= exp_d;
      unload_q    <= unload_d;
      scan_en_q   <= scan_en_d;
      scan_in_q   <= scan_in_d;
      cap_en_q    <= cap_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      response_q  <= response_d;
      fail_bits_q <= fail_bits_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok)               state_d = S_SHIFT_IN;
      S_SHIFT_IN:     if (bit_cnt_q == BIT_LAST)  state_d = S_CAPTURE;
      S_CAPTURE:      if (cap_cnt_q == CAP_LAST)  state_d = S_SHIFT_OUT;
      S_SHIFT_OUT:    if (bit_cnt_q == BIT_LAST)  state_d = S_DONE;
      default:                                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    pat_d       = pat_q;
    exp_d       = exp_q;
    unload_d    = unload_q;
    scan_en_d   = scan_en_q;
    scan_in_d   = 1'b0;
    cap_en_d    = cap_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    response_d  = response_q;
    fail_bits_d = fail_bits_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          pat_d       = pattern_in;
          exp_d       = expected_in;
          unload_d    = '0;
          bit_cnt_d   = '0;
          scan_en_d   = 1'b1;
          scan_in_d   = pattern_in[CHAIN_LEN-1];
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          response_d  = '0;
          fail_bits_d = '0;
        end
      end
      S_SHIFT_IN: begin
        // Pattern register shifts left so the next MSB-first bit is always at CHAIN_LEN-2.
        pat_d     = {pat_q[CHAIN_LEN-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BIT_ONE;
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          cap_cnt_d = '0;
          scan_en_d = 1'b0;
          cap_en_d  = 1'b1;
        end else begin
          scan_in_d = pat_q[CHAIN_LEN-2];
        end
      end
      S_CAPTURE: begin
        cap_cnt_d = cap_cnt_q + CAP_ONE;
        if (cap_cnt_q == CAP_LAST) begin
          cap_cnt_d = '0;
          cap_en_d  = 1'b0;
          scan_en_d = 1'b1;
        end
      end
      S_SHIFT_OUT: begin
        // First sample lands in the MSB after CHAIN_LEN left shifts.
        unload_d  = {unload_q[CHAIN_LEN-2:0], scan_out};
        bit_cnt_d = bit_cnt_q + BIT_ONE;
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d   = '0;
          scan_en_d   = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          response_d  = unload_d;
          pass_d      = (unload_d == exp_q);
          fail_bits_d = unload_d ^ exp_q;
        end
      end
      default: begin
        scan_en_d = 1'b0;
        cap_en_d  = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  assign scan_en   = scan_en_q;
  assign scan_in   = scan_in_q;
  assign cap_en    = cap_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign response  = response_q;
  assign fail_bits = fail_bits_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: two instances (capture depth 1 and 3), each driving an 8-bit scan counter.
module tb_scan_test_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s   [2];
  logic [7:0] pat_s     [2];
  logic [7:0] exp_s     [2];
  logic       scan_en_s [2];
  logic       scan_in_s [2];
  logic       cap_en_s  [2];
  logic       busy_s    [2];
  logic       done_s    [2];
  logic       pass_s    [2];
  logic [7:0] resp_s    [2];
  logic [7:0] fb_s      [2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, want);
    end
  endtask

  function automatic int cap_of(input int id);
    return (id == 0) ? 1 : 3;
  endfunction

  typedef struct {
    logic [7:0] pat;
    logic [7:0] resp;
    logic [7:0] fb;
    logic       ok;
    int         acc;
  } item_t;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int C   = (g == 0) ? 1 : 3;
    localparam int LAT = 2 * N + C;

    logic [7:0] chain = 8'h00;
    logic       so;
    item_t      sb[$];
    int         cyc = 0, busy_cnt = 0, seq = 0, flush_to = 0;
    int         rd = 0, seen = 0, nbits = 0, capn = 0;
    logic [7:0] bits = 8'h00;
    bit         viol = 1'b0;

    assign so = chain[7];

    scan_test_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(C)) dut (
      .clk(clk), .rst(rst), .start(start_s[g]),
      .pattern_in(pat_s[g]), .expected_in(exp_s[g]),
      .scan_en(scan_en_s[g]), .scan_in(scan_in_s[g]), .cap_en(cap_en_s[g]),
      .scan_out(so), .busy(busy_s[g]), .done(done_s[g]), .pass(pass_s[g]),
      .response(resp_s[g]), .fail_bits(fb_s[g])
    );

    // Scan-enabled counter on the far end of the chain.
    always @(posedge clk) begin
      if (scan_en_s[g])     chain <= {chain[6:0], scan_in_s[g]};
      else if (cap_en_s[g]) chain <= chain + 8'd1;
    end

    // Reference: an accepted start yields pattern+C after LAT cycles; no start is taken while an op is in flight.
    always @(posedge clk) begin : model
      item_t it;
      cyc++;
      if (rst) begin
        busy_cnt = 0;
        flush_to = sb.size();
        seq++;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end else if (start_s[g]) begin
        it.pat  = pat_s[g];
        it.resp = 8'(pat_s[g] + C);
        it.ok   = (it.resp == exp_s[g]);
        it.fb   = it.resp ^ exp_s[g];
        it.acc  = cyc;
        sb.push_back(it);
        busy_cnt = LAT;
        seq++;
      end
    end

    always @(negedge clk) begin : monitor
      item_t it;
      if (seq != seen) begin
        seen  = seq;
        nbits = 0;
        bits  = 8'h00;
        capn  = 0;
        viol  = 1'b0;
        if (rd < flush_to) rd = flush_to;
        chk($sformatf("clear%0d", g), {15'd0, pass_s[g], resp_s[g], fb_s[g]}, 32'd0);
      end
      if (scan_en_s[g] && cap_en_s[g]) viol = 1'b1;
      if (cap_en_s[g]) capn++;
      if (scan_en_s[g] && capn == 0 && nbits < N) begin
        bits = {bits[6:0], scan_in_s[g]};
        nbits++;
      end else if (scan_in_s[g]) begin
        viol = 1'b1;
      end
      if (done_s[g]) begin
        if (rd >= sb.size()) begin
          total++;
          bad++;
          $display("FAIL unexpected_done%0d: got=1 want=0", g);
        end else begin
          it = sb[rd];
          rd++;
          chk($sformatf("response%0d", g), resp_s[g], it.resp);
          chk($sformatf("pass%0d", g), pass_s[g], it.ok);
          chk($sformatf("fail_bits%0d", g), fb_s[g], it.fb);
          chk($sformatf("latency%0d", g), cyc - it.acc, LAT);
          chk($sformatf("scan_in_bits%0d", g), bits, it.pat);
          chk($sformatf("cap_cycles%0d", g), capn, C);
          chk($sformatf("protocol%0d", g), viol, 0);
          chk($sformatf("busy_at_done%0d", g), busy_s[g], 0);
        end
      end
    end
  end

  task automatic op_now(input int id, input logic [7:0] p, input logic [7:0] e);
    start_s[id] = 1'b1;
    pat_s[id]   = p;
    exp_s[id]   = e;
    @(negedge clk);
    start_s[id] = 1'b0;
  endtask

  task automatic op(input int id, input logic [7:0] p, input logic [7:0] e);
    @(negedge clk);
    op_now(id, p, e);
  endtask

  task automatic wait_done(input int id);
    for (int i = 0; i < 100; i++) begin
      if (done_s[id]) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL timeout%0d: got=no_done want=done", id);
  endtask

  task automatic chk_zero(input string name, input int id);
    chk(name, {14'd0, scan_en_s[id], scan_in_s[id], cap_en_s[id], busy_s[id],
               done_s[id], pass_s[id], resp_s[id], fb_s[id]}, 32'd0);
  endtask

  task automatic rand_run(input int id, input int cycles);
    logic [7:0] p;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      p           = 8'($urandom);
      start_s[id] = ($urandom_range(0, 3) == 0);
      pat_s[id]   = p;
      exp_s[id]   = ($urandom_range(0, 1) == 1) ? 8'(p + cap_of(id)) : 8'($urandom);
    end
    @(negedge clk);
    start_s[id] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      pat_s[i]   = 8'h00;
      exp_s[i]   = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset0", 0);
    chk_zero("reset1", 1);
    rst = 1'b0;

    op(0, 8'hB3, 8'hB4);
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("hold_resp", resp_s[0], 8'hB4);
    chk("hold_pass", pass_s[0], 1);
    chk("hold_done", done_s[0], 0);

    op(0, 8'hB3, 8'hB5);
    wait_done(0);
    op(0, 8'hFF, 8'h00);
    wait_done(0);
    op(1, 8'h10, 8'h13);
    wait_done(1);

    // Second start mid-load with different data must not disturb the first.
    op(0, 8'h5A, 8'h5B);
    repeat (2) @(negedge clk);
    op_now(0, 8'hC3, 8'h00);
    wait_done(0);

    // Start sampled on the done-entry edge is dropped.
    op(0, 8'h21, 8'h22);
    repeat (2 * N + 1 - 1) @(negedge clk);
    start_s[0] = 1'b1;
    pat_s[0]   = 8'hE0;
    @(negedge clk);
    start_s[0] = 1'b0;
    chk("done_edge_start", done_s[0], 1);
    repeat (40) @(negedge clk);

    // Reset on edge 5 of an operation.
    op(0, 8'h77, 8'h78);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midop_reset", 0);
    rst = 1'b0;

    op(0, 8'h00, 8'h01);
    wait_done(0);
    op_now(0, 8'h42, 8'h43);
    wait_done(0);

    rand_run(0, 300);
    rand_run(1, 300);
    repeat (60) @(negedge clk);
    chk("drain0", g_inst[0].sb.size() - g_inst[0].rd, 0);
    chk("drain1", g_inst[1].sb.size() - g_inst[1].rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
